regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
Shares the register file's single write port between the pipeline writeback stage and NUM_REQ long-latency result producers (load-miss return, divider, coprocessor moves). Pipeline writeback has fixed priority. Side requesters use valid/ready with round-robin on free slots. A starvation counter forces a one-cycle pipeline writeback bubble so no requester waits forever. Outputs drive the register file's RegWrite/WriteReg/WriteData inputs directly.

Parameters:
NUM_REQ, 2, number of side requesters (legal 2..4)
STARVE_LIMIT, 8, consecutive denied cycles before a forced pipeline bubble (legal 2..255)

Ports:
clock  input  1  system clock; all state on posedge
reset  input  1  synchronous, active-high
pipe_we  input  1  pipeline writeback write enable
pipe_reg  input  5  pipeline destination register
pipe_data  input  32  pipeline write data
pipe_stall  output  1  forces writeback bubble next cycle; pipeline must hold pipe_we=0 in any cycle pipe_stall=1
req_valid  input  NUM_REQ  side request valid, one bit per requester
req_reg  input  5*NUM_REQ  destination per requester, requester i at [5i+4:5i]
req_data  input  32*NUM_REQ  data per requester, requester i at [32i+31:32i]
req_ready  output  NUM_REQ  combinational grant, at most one bit high
rf_RegWrite  output  1  registered register-file write enable
rf_WriteReg  output  5  registered register-file write index
rf_WriteData  output  32  registered register-file write data
proto_err  output  1  sticky: pipe_we seen while pipe_stall=1

Behaviour:
- Reset: clock and reset are as decided above: reset is synchronous, active-high; clock is clock. On reset, rf_RegWrite=0, rf_WriteReg=0, rf_WriteData=0, pipe_stall=0, proto_err=0, req_ready=0, rr_ptr=0, all wait counters=0. Reset mid-handshake drops in-flight grants; no write is issued.
- Slot: the write slot is busy when pipe_we=1 and pipe_reg!=0. A pipeline write to $0 does not consume the slot.
- Pipeline path: when pipe_we=1, the write is always taken. Next cycle: rf_RegWrite=(pipe_reg!=0), rf_WriteReg=pipe_reg, rf_WriteData=pipe_data. Latency is 1 cycle.
- Grant:
  - When the slot is free, search valid requesters starting at rr_ptr in increasing index, modulo NUM_REQ. The first one found gets req_ready=1 in the same cycle.
  - The transfer occurs on valid&ready. Next cycle the output registers take that requester's reg/data, and rr_ptr becomes (granted index + 1) mod NUM_REQ.
  - When the slot is busy, req_ready=0.
  - A requester write to $0 still completes the handshake, but rf_RegWrite=0 for it.
- Idle: with no write taken, rf_RegWrite=0 next cycle. rf_WriteReg and rf_WriteData hold their last values.
- Same destination: if the pipeline and a requester target the same register in one cycle, the pipeline wins. The requester stays pending and writes later, so the later write is the final value.
- Wait counters, per requester:
  - Increment when req_valid=1 and req_ready=0, saturating at STARVE_LIMIT.
  - Clear on grant or when req_valid=0.
- Forced bubble:
  - When any counter equals STARVE_LIMIT and pipe_stall=0, pipe_stall goes to 1 on the next edge for exactly one cycle, then returns to 0.
  - pipe_stall cannot re-assert in the cycle immediately after a stall cycle, so the minimum gap is one cycle.
  - In the stall cycle the slot is free. The round-robin search starts at the lowest-index requester whose counter equals STARVE_LIMIT, overriding rr_ptr.
- Protocol error: pipe_we=1 while pipe_stall=1 sets proto_err, which stays set until reset. The pipeline write still wins.
- Requester rules: a requester must hold req_reg and req_data stable while valid and not ready. No dependency from ready to valid is allowed.
- Throughput: one register-file write per cycle maximum.

Test Plan:
- Reset, then pipe_we=1, pipe_reg=5, pipe_data=0xDEADBEEF -> next cycle rf_RegWrite=1, rf_WriteReg=5, rf_WriteData=0xDEADBEEF; req_ready=0 in the request cycle.
- pipe_we=0; req_valid=2'b11 held with reg 7/data 0x11 (req 0) and reg 9/data 0x22 (req 1) -> req 0 granted first, req 1 next cycle; outputs show reg 7/0x11 then reg 9/0x22; rr_ptr ends at 0.
- pipe_we=1 to reg 3 every cycle; req_valid[1]=1 -> req_ready stays 0 for 8 cycles; pipe_stall=1 on the 9th cycle; pipeline drops pipe_we; req 1 granted that cycle; pipe_stall=0 after.
- pipe_we=1, pipe_reg=0 with req_valid[0]=1 to reg 4 -> req 0 granted the same cycle; rf_WriteReg=4; no write to $0 is issued.
- Pipeline writes reg 10 = 0xA while req 0 writes reg 10 = 0xB in the same cycle -> 0xA is written first, 0xB the next cycle.
- Drive pipe_we=1 during a pipe_stall cycle -> proto_err=1, and it holds until reset; assert reset mid-handshake -> next cycle all outputs are 0 and no write occurs.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port between pipeline writeback and round-robin side requesters
module regfile_wport_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    pipe_we,
   input  logic [4:0]              pipe_reg,
   input  logic [31:0]             pipe_data,
   output logic                    pipe_stall,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [5*NUM_REQ-1:0]    req_reg,
   input  logic [32*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    rf_RegWrite,
   output logic [4:0]              rf_WriteReg,
   output logic [31:0]             rf_WriteData,
   output logic                    proto_err
);
   localparam int PW = (NUM_REQ > 2) ? 2 : 1;
   localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

   logic [PW-1:0] r_rr_ptr, w_start, w_idx;
   logic [7:0]    r_cnt [NUM_REQ];
   logic [7:0]    w_cnt_nxt [NUM_REQ];
   logic          r_stall, w_busy, w_found, w_take, w_hit, w_starve;
   logic [4:0]    w_req_reg;
   logic [31:0]   w_req_data;

   assign w_busy     = pipe_we && (pipe_reg != 5'd0);
   assign w_take     = w_found && !w_busy && !reset;
   assign req_ready  = w_take ? (NUM_REQ'(1) << w_idx) : '0;
   assign w_req_reg  = req_reg[5*w_idx +: 5];
   assign w_req_data = req_data[32*w_idx +: 32];
   assign pipe_stall = r_stall;

   // search origin: lowest saturated requester during a forced bubble, otherwise the round-robin pointer
   always_comb begin
      w_start = r_rr_ptr;
      w_hit   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (r_stall && !w_hit && r_cnt[i] == LIM) begin
            w_start = PW'(i);
            w_hit   = 1'b1;
         end
   end

   // first valid requester at or after the search origin, wrapping around
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!w_found && req_valid[(int'(w_start) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_idx   = PW'((int'(w_start) + k) % NUM_REQ);
         end
   end

   // wait counters: count denied cycles while valid, saturate, clear on grant or idle
   always_comb begin
      w_starve = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_cnt_nxt[i] = (!req_valid[i] || req_ready[i]) ? 8'd0 :
                        (r_cnt[i] == LIM) ? LIM : r_cnt[i] + 8'd1;
         w_starve     = w_starve | (w_cnt_nxt[i] == LIM);
      end
   end

   // state: write-port registers, round-robin pointer, counters, bubble and sticky error
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_RegWrite  <= 1'b0;
         rf_WriteReg  <= 5'd0;
         rf_WriteData <= 32'd0;
         r_rr_ptr     <= '0;
         r_stall      <= 1'b0;
         proto_err    <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= 8'd0;
      end else begin
         if (w_busy) begin
            rf_RegWrite  <= 1'b1;
            rf_WriteReg  <= pipe_reg;
            rf_WriteData <= pipe_data;
         end else if (w_take) begin
            rf_RegWrite  <= (w_req_reg != 5'd0);
            rf_WriteReg  <= w_req_reg;
            rf_WriteData <= w_req_data;
         end else if (pipe_we) begin
            rf_RegWrite  <= 1'b0;
            rf_WriteReg  <= pipe_reg;
            rf_WriteData <= pipe_data;
         end else
            rf_RegWrite  <= 1'b0;
         if (w_take) r_rr_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
         r_stall   <= !r_stall && w_starve;
         proto_err <= proto_err | (pipe_we && r_stall);
         for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= w_cnt_nxt[i];
      end
   end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed self-checking bench for the write-port arbiter
module tb_regfile_wport_arbiter;
   logic        clock = 1'b0, reset = 1'b1;
   logic        pipe_we = 1'b0;
   logic [4:0]  pipe_reg = 5'd0;
   logic [31:0] pipe_data = 32'd0;
   logic        pipe_stall;
   logic [1:0]  req_valid = 2'b00;
   logic [9:0]  req_reg = 10'd0;
   logic [63:0] req_data = 64'd0;
   logic [1:0]  req_ready;
   logic        rf_RegWrite;
   logic [4:0]  rf_WriteReg;
   logic [31:0] rf_WriteData;
   logic        proto_err;
   int checks = 0, errors = 0;

   regfile_wport_arbiter #(.NUM_REQ(2), .STARVE_LIMIT(8)) dut (
      .clock(clock), .reset(reset), .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
      .req_ready(req_ready), .rf_RegWrite(rf_RegWrite), .rf_WriteReg(rf_WriteReg),
      .rf_WriteData(rf_WriteData), .proto_err(proto_err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      req_valid = 2'b11;
      step(); step();
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== 38'd0) begin errors++; $display("FAIL reset_rf got %b %h %h want 0 0 0", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      checks++; if ({pipe_stall, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {pipe_stall, proto_err}); end
      req_valid = 2'b00;
      reset = 1'b0;
      step();
   endtask

   task automatic test_pipe();
      pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEADBEEF;
      req_valid = 2'b01; req_reg = {5'd2, 5'd1};
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL pipe_busy_ready got %b want 00", req_ready); end
      step();
      pipe_we = 1'b0; req_valid = 2'b00;
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL pipe_write got %b %0d %h want 1 5 deadbeef", rf_RegWrite, rf_WriteReg, rf_WriteData); end
   endtask

   task automatic test_round_robin();
      req_reg = {5'd9, 5'd7}; req_data = {32'h22, 32'h11}; req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first got %b want 01", req_ready); end
      step();
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd7, 32'h11}) begin errors++; $display("FAIL rr_out0 got %b %0d %h want 1 7 11", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second got %b want 10", req_ready); end
      step();
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd9, 32'h22}) begin errors++; $display("FAIL rr_out1 got %b %0d %h want 1 9 22", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_wrap got %b want 01", req_ready); end
      req_valid = 2'b00;
      step();
      checks++; if (rf_RegWrite !== 1'b0) begin errors++; $display("FAIL rr_idle got %b want 0", rf_RegWrite); end
   endtask

   task automatic test_starve();
      pipe_we = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h33;
      req_valid = 2'b10; req_reg = {5'd12, 5'd0}; req_data = {32'hC1, 32'h0};
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++; if ({req_ready, pipe_stall} !== 3'b000) begin errors++; $display("FAIL starve_wait%0d got ready %b stall %b want 00 0", i, req_ready, pipe_stall); end
         step();
      end
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got %b want 1", pipe_stall); end
      pipe_we = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL starve_grant got %b want 10", req_ready); end
      step();
      req_valid = 2'b00;
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_unstall got %b want 0", pipe_stall); end
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd12, 32'hC1}) begin errors++; $display("FAIL starve_out got %b %0d %h want 1 12 c1", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL starve_proto got %b want 0", proto_err); end
   endtask

   task automatic test_zero_reg();
      pipe_we = 1'b1; pipe_reg = 5'd0; pipe_data = 32'h99;
      req_valid = 2'b01; req_reg = {5'd0, 5'd4}; req_data = {32'h0, 32'h44};
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL zero_grant got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL zero_req_out got %b %0d %h want 1 4 44", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      step();
      pipe_we = 1'b0;
      checks++; if (rf_RegWrite !== 1'b0) begin errors++; $display("FAIL zero_pipe_we got %b want 0", rf_RegWrite); end
   endtask

   task automatic test_same_dest();
      pipe_we = 1'b1; pipe_reg = 5'd10; pipe_data = 32'hA;
      req_valid = 2'b01; req_reg = {5'd0, 5'd10}; req_data = {32'h0, 32'hB};
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL same_busy got %b want 00", req_ready); end
      step();
      pipe_we = 1'b0;
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd10, 32'hA}) begin errors++; $display("FAIL same_pipe got %b %0d %h want 1 10 a", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL same_grant got %b want 01", req_ready); end
      step();
      req_valid = 2'b00;
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b1, 5'd10, 32'hB}) begin errors++; $display("FAIL same_req got %b %0d %h want 1 10 b", rf_RegWrite, rf_WriteReg, rf_WriteData); end
      step();
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData} !== {1'b0, 5'd10, 32'hB}) begin errors++; $display("FAIL idle_hold got %b %0d %h want 0 10 b", rf_RegWrite, rf_WriteReg, rf_WriteData); end
   endtask

   task automatic test_proto_and_reset();
      pipe_we = 1'b1; pipe_reg = 5'd3; pipe_data = 32'h33;
      req_valid = 2'b10; req_reg = {5'd12, 5'd6}; req_data = {32'hC2, 32'h66};
      for (int i = 0; i < 8; i++) step();
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL proto_stall got %b want 1", pipe_stall); end
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL proto_nogrant got %b want 00", req_ready); end
      step();
      pipe_we = 1'b0; req_valid = 2'b00;
      checks++; if ({proto_err, pipe_stall} !== 2'b10) begin errors++; $display("FAIL proto_set got err %b stall %b want 1 0", proto_err, pipe_stall); end
      checks++; if ({rf_RegWrite, rf_WriteReg} !== {1'b1, 5'd3}) begin errors++; $display("FAIL proto_pipe_wins got %b %0d want 1 3", rf_RegWrite, rf_WriteReg); end
      step(); step();
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", proto_err); end
      req_valid = 2'b01; reset = 1'b1;
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_mid_ready got %b want 00", req_ready); end
      step();
      checks++; if ({rf_RegWrite, rf_WriteReg, rf_WriteData, pipe_stall, proto_err} !== 40'd0) begin errors++; $display("FAIL rst_mid_out got %b %0d %h %b %b want all 0", rf_RegWrite, rf_WriteReg, rf_WriteData, pipe_stall, proto_err); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_rr_ptr got %b want 01", req_ready); end
      req_valid = 2'b00;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pipe();
      test_round_robin();
      test_starve();
      test_zero_reg();
      test_same_dest();
      test_proto_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
